hpf_power_meter: RTL
====================

HPF_POWER_METER -- requirements
Module: hpf_power_meter

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 39, width of the signed filter-output word.
REQ-002 SHALL have parameter WIN_LOG2, default 8, log2 of the measurement window length in samples; legal range 1..16.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port y_in  input  IN_WIDTH  signed high-pass filter output sample.
REQ-006 SHALL have port valid_i  input  1  y_in qualifier; one sample accepted per cycle when high.
REQ-007 SHALL have port thresh  input  32  unsigned detect threshold on mean power, sampled at window end.
REQ-008 SHALL have port sample_o  output  16  signed saturated sample.
REQ-009 SHALL have port sample_valid_o  output  1  sample_o qualifier, one-cycle pulse per accepted sample.
REQ-010 SHALL have port sat_o  output  1  high with sample_valid_o when the sample was clipped.
REQ-011 SHALL have port power_o  output  32  unsigned mean of squared saturated samples over the last window.
REQ-012 SHALL have port peak_o  output  16  unsigned peak magnitude over the last window.
REQ-013 SHALL have port meas_valid_o  output  1  one-cycle pulse when power_o/peak_o update.
REQ-014 SHALL have port detect_o  output  1  high while the last window's power_o >= thresh.

Function
REQ-015 SHALL, stage 1, register sample_o = clamp(y_in, -32768, 32767) one cycle after valid_i is high; sample_valid_o follows valid_i with 1-cycle latency.
REQ-016 SHALL assert sat_o exactly when y_in > 32767 or y_in < -32768; sat_o is 0 whenever sample_valid_o is 0.
REQ-017 SHALL, stage 2, on each sample_valid_o cycle add sample_o*sample_o (unsigned 31-bit) into an accumulator of 31+WIN_LOG2 bits; overflow impossible by construction.
REQ-018 SHALL count stage-2 samples with a WIN_LOG2-bit counter; on the sample where the counter equals 2^WIN_LOG2-1, load power_o = (acc + square) >> WIN_LOG2 (truncating), clear acc, wrap counter to 0.
REQ-019 SHALL pulse meas_valid_o one cycle, registered with the power_o update, i.e. 2 cycles after valid_i of the window's last sample.
REQ-020 SHALL hold all state (counter, acc, peak) unchanged on cycles with valid_i low; gaps of any length are allowed.
REQ-021 SHALL compute magnitude as |sample_o| with -32768 mapped to 32767, track the window maximum, load peak_o at window end, and restart tracking from the window's final sample excluded (fresh window starts at 0).
REQ-022 SHALL update detect_o only in the meas_valid_o cycle: 1 if new power_o >= thresh, else 0; hold otherwise.
REQ-023 SHALL accept back-to-back windows with no dead cycle: a sample arriving the cycle after the wrap is sample 0 of the next window.

Reset
REQ-024 SHALL on rst clear sample_o, sample_valid_o, sat_o, power_o, peak_o, meas_valid_o, detect_o, counter, acc and peak tracker to 0.
REQ-025 SHALL discard a partial window when rst asserts mid-window; first window after reset starts with the first valid_i after rst deasserts.
REQ-026 SHALL ignore valid_i in any cycle rst is high.

Configuration
REQ-027 SHALL compile the peak tracker only when macro HPF_METER_PEAK_EN is defined; without it peak_o is constant 0 and no peak logic exists; power, detect and saturation behaviour are identical in both builds.

Verification (WIN_LOG2=2, HPF_METER_PEAK_EN defined unless stated)
REQ-028 SHALL cover: y_in=1000 for 4 consecutive valids -> sample_o=1000, sat_o=0, power_o=1000000, peak_o=1000, one meas_valid_o pulse 2 cycles after 4th valid.
REQ-029 SHALL cover: y_in=40000 then -50000 -> sample_o=32767 then -32768, sat_o=1 both; window of four -50000 -> power_o=1073741824, peak_o=32767.
REQ-030 SHALL cover: samples 100,-200,300,-400 with 3 idle cycles between each -> power_o=75000, peak_o=400, exactly one meas_valid_o.
REQ-031 SHALL cover: thresh=75000 with the window above -> detect_o=1; next window all 0 -> detect_o=0 at its meas_valid_o, held between pulses.
REQ-032 SHALL cover: 2 samples of 5000, rst for 1 cycle, then 4 samples of 10 -> power_o=100, peak_o=10, no meas_valid_o before the 4th post-reset sample.
REQ-033 SHALL cover: HPF_METER_PEAK_EN undefined, scenario REQ-028 -> power_o=1000000, peak_o=0.

Source files
------------

// File: rtl/hpf_power_meter.sv
`default_nettype none
// ============================================================================
// Module      : hpf_power_meter
// Description : Saturates a wide signed high-pass filter output to 16 bits.
//               Accumulates the squared samples over a window of 2^WIN_LOG2
//               accepted samples and reports the mean power and peak
//               magnitude of each window. Flags detection when the mean
//               power reaches a programmable threshold.
//               Optional feature macro: HPF_METER_PEAK_EN
//                 defined   -> peak-magnitude tracker is built
//                 undefined -> peak_o is tied to 0, no peak logic exists
// Revision    : 1.0 - initial release
// ============================================================================
module hpf_power_meter #(
  parameter int IN_WIDTH = 39,
  parameter int WIN_LOG2 = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [IN_WIDTH-1:0] y_in,
  input  logic                       valid_i,
  input  logic        [31:0]         thresh,
  output logic signed [15:0]         sample_o,
  output logic                       sample_valid_o,
  output logic                       sat_o,
  output logic        [31:0]         power_o,
  output logic        [15:0]         peak_o,
  output logic                       meas_valid_o,
  output logic                       detect_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Input is sign-extended to at least 17 bits so the 16-bit clip limits are
  // representable even for narrow IN_WIDTH settings.
  localparam int EXT_W = (IN_WIDTH > 17) ? IN_WIDTH : 17;
  // Largest square is 32768^2 = 2^30, so 31 bits per term; summing
  // 2^WIN_LOG2 terms needs WIN_LOG2 extra bits and can never overflow.
  localparam int SQ_W  = 31;
  localparam int ACC_W = SQ_W + WIN_LOG2;

  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(32767);
  localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-32768);

  // --------------------------------------------------------------------------
  // Stage 1 : saturation
  // --------------------------------------------------------------------------
  logic signed [EXT_W-1:0] y_ext;
  logic                    clip_hi;
  logic                    clip_lo;
  logic signed [15:0]      sample_d;
  logic signed [15:0]      sample_q;
  logic                    sample_valid_q;
  logic                    sat_q;

  assign y_ext   = EXT_W'(y_in);
  assign clip_hi = (y_ext > SAT_MAX);
  assign clip_lo = (y_ext < SAT_MIN);

  // Clamp the extended input to the signed 16-bit range.
  always_comb begin
    sample_d = y_ext[15:0];
    if (clip_hi) begin
      sample_d = 16'sh7FFF;
    end else if (clip_lo) begin
      sample_d = 16'sh8000;
    end
  end

  // Register the saturated sample; it holds its value when no sample arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      sat_q          <= 1'b0;
    end else begin
      sample_valid_q <= valid_i;
      sat_q          <= valid_i & (clip_hi | clip_lo);
      if (valid_i) begin
        sample_q <= sample_d;
      end
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign sat_o          = sat_q;

  // --------------------------------------------------------------------------
  // Stage 2 : magnitude and square of the registered sample
  // --------------------------------------------------------------------------
  logic [15:0]     sample_u;
  logic [15:0]     mag;
  logic [SQ_W-1:0] square;

  // The unsigned magnitude of -32768 is 32768, which still fits in 16 bits,
  // so squaring through the magnitude gives the exact value for every input.
  assign sample_u = $unsigned(sample_q);
  assign mag      = sample_q[15] ? (~sample_u + 16'd1) : sample_u;
  assign square   = {15'd0, mag} * {15'd0, mag};

  // --------------------------------------------------------------------------
  // Stage 2 : window accumulator, sample counter, power and detect
  // --------------------------------------------------------------------------
  logic [WIN_LOG2-1:0] cnt_q;
  logic [WIN_LOG2-1:0] cnt_d;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic [ACC_W-1:0]    acc_sum;
  logic                win_last;
  logic [31:0]         power_q;
  logic [31:0]         power_d;
  logic                meas_valid_q;
  logic                meas_valid_d;
  logic                detect_q;
  logic                detect_d;

  assign acc_sum  = acc_q + {{WIN_LOG2{1'b0}}, square};
  assign win_last = (cnt_q == {WIN_LOG2{1'b1}});

  // Next-state for the window: accumulate, or close the window on its last
  // sample and start the next one immediately with an empty accumulator.
  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    power_d      = power_q;
    meas_valid_d = 1'b0;
    detect_d     = detect_q;
    if (sample_valid_q) begin
      // Counter wraps from all-ones back to zero on the last sample.
      cnt_d = cnt_q + WIN_LOG2'(1);
      if (win_last) begin
        acc_d        = '0;
        // Mean = sum >> WIN_LOG2; the quotient is at most 31 bits wide.
        power_d      = {1'b0, acc_sum[ACC_W-1:WIN_LOG2]};
        meas_valid_d = 1'b1;
        detect_d     = (power_d >= thresh);
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // Window state registers; reset discards any partially filled window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      power_q      <= '0;
      meas_valid_q <= 1'b0;
      detect_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      power_q      <= power_d;
      meas_valid_q <= meas_valid_d;
      detect_q     <= detect_d;
    end
  end

  assign power_o      = power_q;
  assign meas_valid_o = meas_valid_q;
  assign detect_o     = detect_q;

  // --------------------------------------------------------------------------
  // Optional peak-magnitude tracker
  // --------------------------------------------------------------------------
`ifdef HPF_METER_PEAK_EN
  logic [15:0] pk_mag;
  logic [15:0] pk_max;
  logic [15:0] pk_track_q;
  logic [15:0] pk_track_d;
  logic [15:0] peak_q;
  logic [15:0] peak_d;

  // Peak is reported in the positive 16-bit range, so -32768 reads as 32767.
  assign pk_mag = (mag == 16'h8000) ? 16'h7FFF : mag;
  assign pk_max = (pk_mag > pk_track_q) ? pk_mag : pk_track_q;

  // Track the running maximum; publish it and restart from zero at window end.
  always_comb begin
    pk_track_d = pk_track_q;
    peak_d     = peak_q;
    if (sample_valid_q) begin
      if (win_last) begin
        peak_d     = pk_max;
        pk_track_d = '0;
      end else begin
        pk_track_d = pk_max;
      end
    end
  end

  // Peak tracker and published peak registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pk_track_q <= '0;
      peak_q     <= '0;
    end else begin
      pk_track_q <= pk_track_d;
      peak_q     <= peak_d;
    end
  end

  assign peak_o = peak_q;
`else
  assign peak_o = 16'd0;
`endif

endmodule
`default_nettype wire
